// File: rtl/bus_arbiter2_64.sv
// bus_arbiter2_64 -- two-requester round-robin burst arbiter for a shared
// 64-bit bus. A granted requester keeps the bus for its whole burst, which is
// len+1 beats. Each beat is forwarded downstream under a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   req[1:0]   per-requester request / burst-continue
//   len0/len1  burst length minus one, sampled only at grant
//   data0/1    per-requester beat data
//   gnt        registered one-hot grant, 0 when idle
//   beat_ack   per-requester beat-transferred strobe (combinational)
//   out_valid  downstream beat valid
//   out_data   owner's data through the mux2_64 data path
//   out_last   current beat is the last beat of the burst
//   out_ready  downstream accepts the beat this cycle

// mux2_64 -- two-input word mux used as the arbiter data path.
//   i[0], i[1]  candidate words
//   sel         selects i[sel]
//   o           selected word
module mux2_64 #(
   parameter int unsigned SIZE = 64
) (
   input  logic [1:0][SIZE-1:0] i,
   input  logic                 sel,
   output logic [SIZE-1:0]      o
);
   assign o = i[sel];
endmodule

module bus_arbiter2_64 #(
   parameter int unsigned SIZE = 64,
   parameter int unsigned LENW = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [1:0]      req,
   input  logic [LENW-1:0] len0,
   input  logic [LENW-1:0] len1,
   input  logic [SIZE-1:0] data0,
   input  logic [SIZE-1:0] data1,
   output logic [1:0]      gnt,
   output logic [1:0]      beat_ack,
   output logic            out_valid,
   output logic [SIZE-1:0] out_data,
   output logic            out_last,
   input  logic            out_ready
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state;
   logic [LENW-1:0] remaining;
   logic            owner;
   logic            last_winner;
   logic            pick;
   logic            xfer;

   // A lone requester wins outright; on contention the one that did not
   // win last time gets the bus.
   always_comb begin
      pick = ~last_winner;
      if (req == 2'b01) pick = 1'b0;
      else if (req == 2'b10) pick = 1'b1;
   end

   assign out_valid = (state == BUSY) && req[owner];
   assign out_last  = out_valid && (remaining == '0);
   assign xfer      = out_valid && out_ready;
   assign beat_ack  = {xfer & owner, xfer & ~owner};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         gnt         <= '0;
         remaining   <= '0;
         owner       <= 1'b0;
         last_winner <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  state     <= BUSY;
                  owner     <= pick;
                  remaining <= pick ? len1 : len0;
                  gnt       <= pick ? 2'b10 : 2'b01;
               end
            end
            BUSY: begin
               // Burst ends on an abort or on the beat taken at remaining==0;
               // the zero compare is what keeps the counter from wrapping.
               if (!req[owner] || (out_ready && remaining == '0)) begin
                  state       <= IDLE;
                  gnt         <= '0;
                  last_winner <= owner;
               end else if (out_ready) begin
                  remaining <= remaining - 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

   mux2_64 #(.SIZE(SIZE)) u_mux (
      .i   ({data1, data0}),
      .sel (owner),
      .o   (out_data)
   );

endmodule

// File: tb/tb_bus_arbiter2_64.sv
// tb_bus_arbiter2_64 -- directed scenarios with literal expectations, then a
// randomized run compared every cycle against a transaction-level model.
module tb_bus_arbiter2_64;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req = '0;
   logic [3:0]  len0 = '0, len1 = '0;
   logic [63:0] data0 = '0, data1 = '0;
   logic [1:0]  gnt, beat_ack;
   logic        out_valid, out_last;
   logic [63:0] out_data;
   logic        out_ready = 1'b0;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   bit checking = 1'b0;

   bus_arbiter2_64 #(.SIZE(64), .LENW(4)) dut (
      .clk(clk), .reset(reset), .req(req), .len0(len0), .len1(len1),
      .data0(data0), .data1(data1), .gnt(gnt), .beat_ack(beat_ack),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Transaction-level model: a burst is an owner plus a count of beats
   // still to deliver (including the current one).
   bit m_busy;
   int m_owner, m_left, m_lastw;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy = 0; m_owner = 0; m_left = 0; m_lastw = 1;
      end else if (!m_busy) begin
         if (req != 2'b00) begin
            if (req == 2'b01)      m_owner = 0;
            else if (req == 2'b10) m_owner = 1;
            else                   m_owner = (m_lastw == 0) ? 1 : 0;
            m_left = (m_owner == 1 ? int'(len1) : int'(len0)) + 1;
            m_busy = 1;
         end
      end else if (!req[m_owner]) begin
         m_busy = 0; m_lastw = m_owner;
      end else if (out_ready) begin
         if (m_left == 1) begin m_busy = 0; m_lastw = m_owner; end
         else m_left = m_left - 1;
      end
   end

   // Single compare process, mid-cycle when all outputs have settled.
   always @(negedge clk) begin
      if (checking) begin
         logic [1:0]  e_gnt, e_ack;
         logic        e_valid, e_last;
         logic [63:0] e_data;
         e_gnt   = m_busy ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
         e_valid = m_busy && req[m_owner];
         e_last  = e_valid && (m_left == 1);
         e_ack   = (e_valid && out_ready) ? e_gnt : 2'b00;
         e_data  = (m_owner == 1) ? data1 : data0;
         chk("m_gnt", 64'(gnt), 64'(e_gnt));
         chk("m_valid", 64'(out_valid), 64'(e_valid));
         chk("m_last", 64'(out_last), 64'(e_last));
         chk("m_ack", 64'(beat_ack), 64'(e_ack));
         chk("m_data", out_data, e_data);
         chk("inv_gnt_not_11", 64'(gnt != 2'b11), 64'd1);
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      #2 reset = 1'b0;
      #3 req = '0; out_ready = 1'b0;
      @(negedge clk) reset = 1'b1;
   endtask

   initial begin
      logic [63:0] a, b, c;
      reset = 1'b0;
      #12;
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ack", 64'(beat_ack), 64'd0);
      data0 = 64'h1111; #1;
      chk("rst_data", out_data, 64'h1111);
      @(negedge clk) reset = 1'b1;
      checking = 1'b1;

      // Single burst of 3 beats from requester 0.
      a = 64'hA; b = 64'hB; c = 64'hC;
      step(); req = 2'b01; len0 = 4'd2; out_ready = 1'b1; data0 = a; #1;
      chk("t1_idle_gnt", 64'(gnt), 64'd0);
      step(); #1;
      chk("t1_gnt", 64'(gnt), 64'b01);
      chk("t1_ackA", 64'(beat_ack), 64'b01);
      chk("t1_dataA", out_data, a);
      chk("t1_lastA", 64'(out_last), 64'd0);
      step(); data0 = b; #1;
      chk("t1_dataB", out_data, b);
      chk("t1_lastB", 64'(out_last), 64'd0);
      step(); data0 = c; #1;
      chk("t1_dataC", out_data, c);
      chk("t1_lastC", 64'(out_last), 64'd1);
      chk("t1_ackC", 64'(beat_ack), 64'b01);
      step(); req = 2'b00; #1;
      chk("t1_end_gnt", 64'(gnt), 64'd0);

      // Contention, single-beat bursts alternate starting with requester 0.
      do_reset();
      step(); req = 2'b11; len0 = 0; len1 = 0; out_ready = 1'b1;
      data0 = 64'hD0; data1 = 64'hD1; #1;
      chk("t2_gnt0", 64'(gnt), 64'b00);
      step(); #1;
      chk("t2_gnt1", 64'(gnt), 64'b01);
      chk("t2_last1", 64'(out_last), 64'd1);
      chk("t2_data1", out_data, 64'hD0);
      step(); #1; chk("t2_gnt2", 64'(gnt), 64'b00);
      step(); #1;
      chk("t2_gnt3", 64'(gnt), 64'b10);
      chk("t2_data3", out_data, 64'hD1);
      chk("t2_last3", 64'(out_last), 64'd1);
      step(); #1; chk("t2_gnt4", 64'(gnt), 64'b00);
      step(); #1; chk("t2_gnt5", 64'(gnt), 64'b01);

      // Backpressure on a 2-beat burst from requester 1.
      do_reset();
      step(); req = 2'b10; len1 = 4'd1; out_ready = 1'b0; data1 = 64'hBEEF;
      for (int i = 0; i < 3; i++) begin
         step(); #1;
         chk("t3_stall_valid", 64'(out_valid), 64'd1);
         chk("t3_stall_ack", 64'(beat_ack), 64'd0);
         chk("t3_stall_last", 64'(out_last), 64'd0);
      end
      step(); out_ready = 1'b1; #1;
      chk("t3_beat1_ack", 64'(beat_ack), 64'b10);
      chk("t3_beat1_last", 64'(out_last), 64'd0);
      step(); #1;
      chk("t3_beat2_ack", 64'(beat_ack), 64'b10);
      chk("t3_beat2_last", 64'(out_last), 64'd1);
      step(); req = 2'b00; #1;
      chk("t3_end_gnt", 64'(gnt), 64'd0);

      // Abort after 2 beats; pending requester 1 gets the bus next.
      do_reset();
      step(); req = 2'b01; len0 = 4'd5; len1 = 4'd0; out_ready = 1'b1;
      step(); #1; chk("t4_b1_ack", 64'(beat_ack), 64'b01);
      step(); #1; chk("t4_b2_ack", 64'(beat_ack), 64'b01);
      step(); req = 2'b10; #1;
      chk("t4_abort_valid", 64'(out_valid), 64'd0);
      chk("t4_abort_last", 64'(out_last), 64'd0);
      chk("t4_abort_ack", 64'(beat_ack), 64'd0);
      step(); #1; chk("t4_idle_gnt", 64'(gnt), 64'd0);
      step(); #1; chk("t4_next_gnt", 64'(gnt), 64'b10);

      // Maximum length: 16 beats, then a one-cycle bubble.
      do_reset();
      step(); req = 2'b01; len0 = 4'd15; out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         step(); #1;
         chk("t5_ack", 64'(beat_ack), 64'b01);
         chk("t5_last", 64'(out_last), 64'(i == 15));
      end
      step(); #1; chk("t5_bubble", 64'(gnt), 64'd0);
      step(); #1; chk("t5_regrant", 64'(gnt), 64'b01);

      // Asynchronous reset mid-burst.
      do_reset();
      step(); req = 2'b01; len0 = 4'd5; out_ready = 1'b1;
      step(); #2;
      chk("t6_pre_valid", 64'(out_valid), 64'd1);
      reset = 1'b0; #1;
      chk("t6_gnt", 64'(gnt), 64'd0);
      chk("t6_valid", 64'(out_valid), 64'd0);
      chk("t6_last", 64'(out_last), 64'd0);
      chk("t6_ack", 64'(beat_ack), 64'd0);
      req = 2'b11;
      @(negedge clk) reset = 1'b1;
      step(); #1; chk("t6_first_gnt", 64'(gnt), 64'b01);

      // Randomized run with occasional mid-cycle resets.
      for (int n = 0; n < 4000; n++) begin
         step();
         req       = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0 && req == 2'b00) req = 2'b11;
         len0      = 4'($urandom);
         len1      = 4'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         data0     = {$urandom, $urandom};
         data1     = {$urandom, $urandom};
         if ($urandom_range(0, 299) == 0) begin
            #1 reset = 1'b0;
            @(negedge clk) reset = 1'b1;
         end
      end

      step();
      checking = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/bus_arbiter2_64.md
Name: bus_arbiter2_64

Overview:
- Two-requester round-robin arbiter that shares one 64-bit bus among burst transfers.
- Each requester presents a data word and a burst length. The arbiter grants one requester at a time, holds the grant for the whole burst, and forwards that requester's data downstream under a valid/ready handshake.
- The data path is one mux2_64 instance: i[0]=data0, i[1]=data1, sel=owner.
- Sits between two producers (e.g. ALU result path and load path) and a shared write/bus port.

Parameters:
- SIZE, 64, data width in bits; passed to mux2_64.
- LENW, 4, width of the burst-length fields. A burst is len+1 beats, so 1 to 2^LENW beats.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately.
- req  input  2  req[k]=1: requester k wants the bus, or is continuing its burst.
- len0  input  LENW  burst length minus 1 for requester 0; sampled only at grant.
- len1  input  LENW  burst length minus 1 for requester 1; sampled only at grant.
- data0  input  SIZE  requester 0 data for the current beat.
- data1  input  SIZE  requester 1 data for the current beat.
- gnt  output  2  one-hot grant, registered; 0 when idle.
- beat_ack  output  2  beat_ack[k]=1 for a cycle in which requester k's beat transfers; combinational.
- out_valid  output  1  downstream beat valid.
- out_data  output  SIZE  data from the mux2_64 output (the owner's data).
- out_last  output  1  current beat is the final beat of the burst.
- out_ready  input  1  downstream accepts the beat this cycle.

Behaviour:
- Reset values (reset=0):
  - state=IDLE, gnt=2'b00, remaining=0, owner=0, last_winner=1.
  - out_valid=0, out_last=0, beat_ack=2'b00.
  - out_data follows data0, since sel=owner=0.
- State IDLE:
  - gnt=0 and out_valid=0.
  - If req!=0 at a rising edge, go to BUSY.
  - Owner choice: the single requester if only one is asserting; otherwise !last_winner.
  - On that edge: remaining <= len of the owner; gnt <= onehot(owner).
- State BUSY:
  - out_valid = req[owner].
  - Transfer occurs when out_valid && out_ready; then beat_ack[owner]=1, and beat_ack[!owner]=0 always.
  - out_last = out_valid && (remaining==0).
  - Transfer with remaining>0: remaining decrements by 1.
  - Transfer with remaining==0: next state IDLE, gnt <= 0, last_winner <= owner.
  - out_ready=0 with req[owner]=1: stall. Hold state, remaining and gnt. out_data tracks the owner's live data; the requester must hold its data stable.
  - req[owner]=0 (abort): out_valid=0 and no transfer. At the next edge go to IDLE, gnt <= 0, last_winner <= owner. The unused beats are discarded.
  - The non-owner's req is ignored while BUSY; it is considered in IDLE.
- Latency:
  - A request sampled at edge N gives gnt=1 after edge N.
  - The first beat can transfer in the cycle after edge N.
  - Exactly one IDLE cycle separates consecutive bursts.
- Counter:
  - remaining is LENW bits.
  - It never decrements below 0; the end-of-burst compare at 0 is what prevents wrap-around.
  - len is not re-sampled mid-burst.
- Reset mid-burst: all outputs go to their reset values asynchronously. No beat_ack or out_last is produced afterward; the burst is lost.
- Invariants:
  - gnt is never 2'b11.
  - out_valid=1 implies gnt!=0.
  - beat_ack is a subset of gnt.

Test Plan:
- Reset, then req=2'b01, len0=2, out_ready=1 held.
  - gnt=01 one cycle later.
  - 3 beats transfer with data0 values A,B,C.
  - beat_ack[0]=1 on each beat; out_last=1 only on C.
  - IDLE next cycle.
- Contention: req=2'b11 continuously, len0=len1=0.
  - Grants alternate 01, 00, 10, 00, 01, ... starting with requester 0.
  - Each burst is 1 beat with out_last=1.
  - out_data matches data0/data1 respectively.
- Backpressure: requester 1 granted with len1=1 and out_ready=0 for 3 cycles.
  - out_valid=1 for those 3 cycles, no beat_ack, remaining held at 1.
  - Then out_ready=1: two beats transfer and out_last is on the second.
- Abort: requester 0 granted with len0=5; drop req[0] after 2 beats.
  - out_valid=0 and no out_last.
  - IDLE next cycle.
  - A pending req[1] is granted the following cycle, since last_winner=0.
- Max length: len0=15.
  - Exactly 16 beats, out_last on the 16th.
  - No counter wrap; a 17th cycle with req[0]=1 starts a new burst only after the IDLE bubble.
- Async reset: assert reset=0 mid-burst between clock edges.
  - gnt, out_valid, out_last and beat_ack drop immediately.
  - After release, req=2'b11 grants requester 0 first.
